// File: rtl/lcd_image_pkg.sv
// Shared types and constants for the 8x8 grayscale LCD image controller.
package lcd_image_pkg;

    localparam int unsigned IMG_W     = 8;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned NPIX      = IMG_W * IMG_W;
    localparam int unsigned ADDR_W    = 6;
    localparam int unsigned COORD_W   = 3;
    localparam int unsigned CNT_W     = ADDR_W + 1;
    localparam int unsigned RST_POINT = 4;

    typedef enum logic [2:0] {
        CMD_WRITE = 3'd0,
        CMD_UP    = 3'd1,
        CMD_DOWN  = 3'd2,
        CMD_LEFT  = 3'd3,
        CMD_RIGHT = 3'd4,
        CMD_AVG   = 3'd5,
        CMD_MIRX  = 3'd6,
        CMD_MIRY  = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    typedef logic [PIX_W-1:0] pix_t;

    // 2x2 operation window: top-left, top-right, bottom-left, bottom-right
    typedef struct packed {
        pix_t tl;
        pix_t tr;
        pix_t bl;
        pix_t br;
    } window_t;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [COORD_W-1:0] row,
                                                   input logic [COORD_W-1:0] col);
        return ADDR_W'(row * IMG_W + col);
    endfunction

    // Full-precision sum, then floor divide by four
    function automatic pix_t win_avg(input window_t w);
        logic [PIX_W+1:0] s;
        s = (PIX_W+2)'(w.tl) + (PIX_W+2)'(w.tr) + (PIX_W+2)'(w.bl) + (PIX_W+2)'(w.br);
        return PIX_W'(s >> 2);
    endfunction

endpackage

// File: rtl/lcd_pixel_buffer.sv
// 64x8 image register file: load port, 2x2 window read/write port, registered read port.
module lcd_pixel_buffer
    import lcd_image_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_en,
    input  logic [ADDR_W-1:0]  ld_addr,
    input  pix_t               ld_data,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    output window_t            win,
    input  logic               win_we,
    input  window_t            win_wdata,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output pix_t               rd_data
);

    pix_t              mem [NPIX];
    logic [ADDR_W-1:0] a_tl;
    logic [ADDR_W-1:0] a_tr;
    logic [ADDR_W-1:0] a_bl;
    logic [ADDR_W-1:0] a_br;

    always_comb begin
        a_tl = pix_addr(y - COORD_W'(1), x - COORD_W'(1));
        a_tr = pix_addr(y - COORD_W'(1), x);
        a_bl = pix_addr(y, x - COORD_W'(1));
        a_br = pix_addr(y, x);
    end

    assign win = '{tl: mem[a_tl], tr: mem[a_tr], bl: mem[a_bl], br: mem[a_br]};

    // Contents are don't-care after reset, so the array itself is not reset
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end else if (win_we) begin
            mem[a_tl] <= win_wdata.tl;
            mem[a_tr] <= win_wdata.tr;
            mem[a_bl] <= win_wdata.bl;
            mem[a_br] <= win_wdata.br;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/lcd_image_ctrl.sv
// Loads an 8x8 image from IROM, runs 2x2 window commands, then dumps the image to IRB.
module lcd_image_ctrl
    import lcd_image_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        cmd,
    input  logic              cmd_valid,
    input  logic [PIX_W-1:0]  IROM_Q,
    output logic              IROM_EN,
    output logic [ADDR_W-1:0] IROM_A,
    output logic              IRB_RW,
    output logic [PIX_W-1:0]  IRB_D,
    output logic [ADDR_W-1:0] IRB_A,
    output logic              busy,
    output logic              done
);

    state_e             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [COORD_W-1:0] px, px_n, py, py_n;
    cmd_e               cmd_r, cmd_r_n;
    logic               rom_vld, rom_vld_n;
    logic [ADDR_W-1:0]  rom_addr, rom_addr_n;
    logic               irom_en_n, irb_rw_n, busy_n, done_n;
    logic [ADDR_W-1:0]  irom_a_n, irb_a_n;

    window_t            win, win_wdata_c;
    logic               ld_en_c, win_we_c, rd_en_c;

    lcd_pixel_buffer u_buf (
        .clk       (clk),
        .reset     (reset),
        .ld_en     (ld_en_c),
        .ld_addr   (rom_addr),
        .ld_data   (IROM_Q),
        .x         (px),
        .y         (py),
        .win       (win),
        .win_we    (win_we_c),
        .win_wdata (win_wdata_c),
        .rd_en     (rd_en_c),
        .rd_addr   (cnt[ADDR_W-1:0]),
        .rd_data   (IRB_D)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_LOAD;
            cnt      <= '0;
            px       <= COORD_W'(RST_POINT);
            py       <= COORD_W'(RST_POINT);
            cmd_r    <= CMD_WRITE;
            rom_vld  <= 1'b0;
            rom_addr <= '0;
            IROM_EN  <= 1'b1;
            IROM_A   <= '0;
            IRB_RW   <= 1'b1;
            IRB_A    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            px       <= px_n;
            py       <= py_n;
            cmd_r    <= cmd_r_n;
            rom_vld  <= rom_vld_n;
            rom_addr <= rom_addr_n;
            IROM_EN  <= irom_en_n;
            IROM_A   <= irom_a_n;
            IRB_RW   <= irb_rw_n;
            IRB_A    <= irb_a_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        px_n        = px;
        py_n        = py;
        cmd_r_n     = cmd_r;
        rom_vld_n   = 1'b0;
        rom_addr_n  = rom_addr;
        irom_en_n   = 1'b1;
        irom_a_n    = IROM_A;
        irb_rw_n    = 1'b1;
        irb_a_n     = IRB_A;
        busy_n      = busy;
        done_n      = done;
        ld_en_c     = 1'b0;
        win_we_c    = 1'b0;
        win_wdata_c = win;
        rd_en_c     = 1'b0;

        case (state)
            S_LOAD: begin
                busy_n = 1'b1;
                if (cnt < CNT_W'(NPIX)) begin
                    irom_en_n = 1'b0;
                    irom_a_n  = cnt[ADDR_W-1:0];
                    cnt_n     = cnt + CNT_W'(1);
                end
                // ROM data trails the issued address by one cycle
                rom_vld_n  = ~IROM_EN;
                rom_addr_n = IROM_A;
                if (rom_vld) begin
                    ld_en_c = 1'b1;
                    if (rom_addr == ADDR_W'(NPIX - 1)) begin
                        state_n = S_IDLE;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                    end
                end
            end
            S_IDLE: begin
                if (cmd_valid) begin
                    busy_n  = 1'b1;
                    cmd_r_n = cmd_e'(cmd);
                    if (cmd_e'(cmd) == CMD_WRITE) begin
                        state_n = S_WRITE;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                case (cmd_r)
                    CMD_UP:    if (py > COORD_W'(1)) py_n = py - COORD_W'(1);
                    CMD_DOWN:  if (py < COORD_W'(IMG_W - 1)) py_n = py + COORD_W'(1);
                    CMD_LEFT:  if (px > COORD_W'(1)) px_n = px - COORD_W'(1);
                    CMD_RIGHT: if (px < COORD_W'(IMG_W - 1)) px_n = px + COORD_W'(1);
                    CMD_AVG: begin
                        win_we_c    = 1'b1;
                        win_wdata_c = '{tl: win_avg(win), tr: win_avg(win),
                                        bl: win_avg(win), br: win_avg(win)};
                    end
                    CMD_MIRX: begin
                        win_we_c    = 1'b1;
                        win_wdata_c = '{tl: win.bl, tr: win.br, bl: win.tl, br: win.tr};
                    end
                    CMD_MIRY: begin
                        win_we_c    = 1'b1;
                        win_wdata_c = '{tl: win.tr, tr: win.tl, bl: win.br, br: win.bl};
                    end
                    default: ;
                endcase
            end
            S_WRITE: begin
                busy_n = 1'b1;
                if (cnt < CNT_W'(NPIX)) begin
                    irb_rw_n = 1'b0;
                    irb_a_n  = cnt[ADDR_W-1:0];
                    rd_en_c  = 1'b1;
                    cnt_n    = cnt + CNT_W'(1);
                end else begin
                    state_n = S_DONE;
                    done_n  = 1'b1;
                end
            end
            S_DONE: begin
                busy_n = 1'b1;
                done_n = 1'b1;
            end
            default: state_n = S_LOAD;
        endcase
    end

endmodule

// File: tb/tb_lcd_image_ctrl.sv
// Directed bench for lcd_image_ctrl with behavioural IROM/IRB models.
module tb_lcd_image_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] cmd = 3'd0;
    logic       cmd_valid = 1'b0;
    logic [7:0] IROM_Q = 8'd0;
    logic       IROM_EN;
    logic [5:0] IROM_A;
    logic       IRB_RW;
    logic [7:0] IRB_D;
    logic [5:0] IRB_A;
    logic       busy;
    logic       done;

    logic [7:0] rom [64];
    logic [7:0] ram [64];
    logic [7:0] exp_img [64];
    logic       ram_clr = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int lat;

    lcd_image_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (IROM_Q),
        .IROM_EN   (IROM_EN),
        .IROM_A    (IROM_A),
        .IRB_RW    (IRB_RW),
        .IRB_D     (IRB_D),
        .IRB_A     (IRB_A),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous ROM and RAM macros
    always @(posedge clk) begin
        if (!IROM_EN) IROM_Q <= rom[IROM_A];
        if (ram_clr) begin
            for (int k = 0; k < 64; k++) ram[k] <= 8'hxx;
        end else if (!IRB_RW) begin
            ram[IRB_A] <= IRB_D;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic wait_idle(input string tag, input int max);
        int i = 0;
        while (busy !== 1'b0 && i < max) begin
            @(negedge clk);
            i++;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic set_ramp();
        for (int k = 0; k < 64; k++) begin
            rom[k]     = 8'(k);
            exp_img[k] = 8'(k);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_idle("load_done", 100);
    endtask

    task automatic send(input logic [2:0] c);
        @(negedge clk);
        cmd       = c;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle($sformatf("cmd%0d_idle", c), 10);
    endtask

    task automatic check_image(input string tag);
        for (int k = 0; k < 64; k++)
            check($sformatf("%s_irb%0d", tag, k), 32'(ram[k]), 32'(exp_img[k]));
    endtask

    task automatic run_write(input string tag);
        int i = 0;
        @(negedge clk);
        ram_clr = 1'b1;
        @(negedge clk);
        ram_clr   = 1'b0;
        cmd       = 3'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        while (done !== 1'b1 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 1);
        check({tag, "_rw_idle"}, 32'(IRB_RW), 1);
        check_image(tag);
    endtask

    initial begin
        // Reset values and LOAD address sequence
        set_ramp();
        #1 reset = 1'b1;
        #2;
        check("rst_irom_en", 32'(IROM_EN), 1);
        check("rst_irom_a", 32'(IROM_A), 0);
        check("rst_irb_rw", 32'(IRB_RW), 1);
        check("rst_irb_d", 32'(IRB_D), 0);
        check("rst_irb_a", 32'(IRB_A), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_done", 32'(done), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        lat = 1;
        check("load_first_en", 32'(IROM_EN), 0);
        check("load_first_a", 32'(IROM_A), 0);
        @(posedge clk); #1;
        lat = 2;
        check("load_second_a", 32'(IROM_A), 1);
        check("load_irb_rw", 32'(IRB_RW), 1);
        while (busy === 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("load_latency_ok", 32'(lat >= 64 && lat <= 67), 1);
        check("idle_irom_en", 32'(IROM_EN), 1);

        // Plain load and write-back
        run_write("plain");
        @(negedge clk);
        cmd       = 3'd5;
        cmd_valid = 1'b1;
        repeat (4) @(negedge clk);
        cmd_valid = 1'b0;
        check("done_hold_done", 32'(done), 1);
        check("done_hold_busy", 32'(busy), 1);
        check("done_hold_rw", 32'(IRB_RW), 1);

        // Average at (4,4): (27+28+35+36)/4 = 31
        set_ramp();
        do_reset();
        send(3'd5);
        exp_img[27] = 8'd31; exp_img[28] = 8'd31; exp_img[35] = 8'd31; exp_img[36] = 8'd31;
        run_write("avg");

        // Mirror X at (4,4)
        set_ramp();
        do_reset();
        send(3'd6);
        exp_img[27] = 8'd35; exp_img[28] = 8'd36; exp_img[35] = 8'd27; exp_img[36] = 8'd28;
        run_write("mirx");

        // Mirror Y at (4,4)
        set_ramp();
        do_reset();
        send(3'd7);
        exp_img[27] = 8'd28; exp_img[28] = 8'd27; exp_img[35] = 8'd36; exp_img[36] = 8'd35;
        run_write("miry");

        // Saturate to (1,1): (0+1+8+9)/4 = 4
        set_ramp();
        do_reset();
        repeat (5) send(3'd1);
        repeat (5) send(3'd3);
        send(3'd5);
        exp_img[0] = 8'd4; exp_img[1] = 8'd4; exp_img[8] = 8'd4; exp_img[9] = 8'd4;
        run_write("sat_ul");

        // Saturate to (7,7): (54+55+62+63)/4 = 58
        set_ramp();
        do_reset();
        repeat (5) send(3'd2);
        repeat (5) send(3'd4);
        send(3'd5);
        exp_img[54] = 8'd58; exp_img[55] = 8'd58; exp_img[62] = 8'd58; exp_img[63] = 8'd58;
        run_write("sat_lr");

        // cmd_valid held high: RIGHT on accept cycles, LEFT while busy must be ignored
        set_ramp();
        do_reset();
        @(negedge clk);
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cmd = (i % 2 == 0) ? 3'd4 : 3'd3;
            @(posedge clk); #1;
            check($sformatf("hs_busy%0d", i), 32'(busy), (i % 2 == 0) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        // Point now (7,4): (30+31+38+39)/4 = 34
        send(3'd5);
        exp_img[30] = 8'd34; exp_img[31] = 8'd34; exp_img[38] = 8'd34; exp_img[39] = 8'd34;
        run_write("hs");

        // Near-full-scale averaging: 3x255+254 -> 254, then 4x255 -> 255
        for (int k = 0; k < 64; k++) begin
            rom[k]     = 8'd255;
            exp_img[k] = 8'd255;
        end
        rom[36] = 8'd254;
        do_reset();
        send(3'd5);
        send(3'd3);
        send(3'd3);
        send(3'd5);
        exp_img[27] = 8'd254; exp_img[28] = 8'd254; exp_img[35] = 8'd254; exp_img[36] = 8'd254;
        run_write("full");

        // Asynchronous reset in the middle of WRITE, then full reload
        set_ramp();
        do_reset();
        send(3'd7);
        @(negedge clk);
        cmd       = 3'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_write_rw", 32'(IRB_RW), 0);
        #2 reset = 1'b1;
        #1;
        check("arst_irb_rw", 32'(IRB_RW), 1);
        check("arst_irb_a", 32'(IRB_A), 0);
        check("arst_irb_d", 32'(IRB_D), 0);
        check("arst_busy", 32'(busy), 1);
        check("arst_done", 32'(done), 0);
        check("arst_irom_en", 32'(IROM_EN), 1);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("reload_irom_en", 32'(IROM_EN), 0);
        check("reload_irom_a", 32'(IROM_A), 0);
        wait_idle("reload_done", 100);
        run_write("reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
